// File: rtl/destruct_pkg.sv
// Shared definitions for the self-destruct sequencer: state codes and LED patterns.
package destruct_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARMING    = 3'd1,
        ST_COUNTDOWN = 3'd2,
        ST_COOLDOWN  = 3'd3,
        ST_DETONATE  = 3'd4
    } state_t;

    localparam logic [7:0] LED_OFF  = 8'h00;
    localparam logic [7:0] LED_FULL = 8'hFF;
    localparam logic [7:0] LED_COOL = 8'hAA;

endpackage

// File: rtl/tick_counter.sv
// Modulo-MAX enable counter; done is high on the enabled cycle that wraps MAX-1 back to 0.
module tick_counter #(
    parameter int MAX = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam int W = (MAX > 1) ? $clog2(MAX) : 1;
    localparam logic [W-1:0] LAST = W'(MAX - 1);

    logic [W-1:0] count_reg;

    assign done = en && (count_reg == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= done ? '0 : count_reg + W'(1);
        end
    end

endmodule

// File: rtl/destruct_sequencer.sv
// Self-destruct control FSM: 2-of-3 damage rule with arming filter, 8-step LED
// countdown with blink, abort cooldown and sticky detonation. ARM_TICKS must be >= 2.
module destruct_sequencer
    import destruct_pkg::*;
#(
    parameter int ARM_TICKS   = 3,
    parameter int STEP_TICKS  = 100,
    parameter int BLINK_TICKS = 33,
    parameter int COOL_TICKS  = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       in_combat,
    input  logic       danger,
    input  logic       damaged,
    input  logic       immobilized,
    input  logic       abort,
    output logic [7:0] leds,
    output logic [2:0] state,
    output logic       detonate
);

    state_t     state_reg, state_next;
    logic [7:0] bar_reg, bar_next;
    logic [7:0] leds_reg, leds_next;
    logic       phase_reg, phase_next;
    logic       detonate_reg, detonate_next;

    logic critical, qualify, stop;
    logic arm_done, step_done, blink_done, cool_done;
    logic in_arm_path, in_count, in_cool;

    assign critical    = (danger & damaged) | (danger & immobilized) | (damaged & immobilized);
    assign qualify     = in_combat & critical;
    assign stop        = abort | ~in_combat;
    assign in_arm_path = (state_reg == ST_IDLE) || (state_reg == ST_ARMING);
    assign in_count    = (state_reg == ST_COUNTDOWN);
    assign in_cool     = (state_reg == ST_COOLDOWN);

    // Counters are held cleared outside their own state, so each entry starts from zero.
    tick_counter #(.MAX(ARM_TICKS)) u_arm (
        .clk  (clk),
        .rst  (rst),
        .clr  (~in_arm_path | (tick & (state_reg == ST_ARMING) & ~qualify)),
        .en   (tick & qualify & in_arm_path),
        .done (arm_done)
    );

    tick_counter #(.MAX(STEP_TICKS)) u_step (
        .clk  (clk),
        .rst  (rst),
        .clr  (~in_count),
        .en   (tick & in_count & ~stop),
        .done (step_done)
    );

    tick_counter #(.MAX(BLINK_TICKS)) u_blink (
        .clk  (clk),
        .rst  (rst),
        .clr  (~in_count),
        .en   (tick & in_count & ~stop),
        .done (blink_done)
    );

    tick_counter #(.MAX(COOL_TICKS)) u_cool (
        .clk  (clk),
        .rst  (rst),
        .clr  (~in_cool),
        .en   (tick & in_cool),
        .done (cool_done)
    );

    always_comb begin
        state_next    = state_reg;
        bar_next      = bar_reg;
        phase_next    = phase_reg;
        leds_next     = leds_reg;
        detonate_next = detonate_reg;
        case (state_reg)
            ST_IDLE: begin
                if (tick && qualify) begin
                    state_next = ST_ARMING;
                    leds_next  = LED_OFF;
                end
            end
            ST_ARMING: begin
                if (tick) begin
                    if (!qualify) begin
                        state_next = ST_IDLE;
                    end else if (arm_done) begin
                        state_next = ST_COUNTDOWN;
                        bar_next   = LED_FULL;
                        phase_next = 1'b1;
                        leds_next  = LED_FULL;
                    end
                end
            end
            ST_COUNTDOWN: begin
                if (tick) begin
                    if (stop) begin
                        state_next = ST_COOLDOWN;
                        leds_next  = LED_COOL;
                    end else begin
                        bar_next   = step_done ? (bar_reg >> 1) : bar_reg;
                        phase_next = phase_reg ^ blink_done;
                        if (step_done && (bar_next == LED_OFF)) begin
                            state_next    = ST_DETONATE;
                            leds_next     = LED_FULL;
                            detonate_next = 1'b1;
                        end else begin
                            leds_next = phase_next ? bar_next : LED_OFF;
                        end
                    end
                end
            end
            ST_COOLDOWN: begin
                if (cool_done) begin
                    state_next = ST_IDLE;
                    leds_next  = LED_OFF;
                end
            end
            ST_DETONATE: begin
            end
            default: begin
                // Unreachable codes recover to IDLE without waiting for a tick.
                state_next    = ST_IDLE;
                bar_next      = LED_FULL;
                phase_next    = 1'b1;
                leds_next     = LED_OFF;
                detonate_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            bar_reg      <= LED_FULL;
            phase_reg    <= 1'b1;
            leds_reg     <= LED_OFF;
            detonate_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            bar_reg      <= bar_next;
            phase_reg    <= phase_next;
            leds_reg     <= leds_next;
            detonate_reg <= detonate_next;
        end
    end

    assign leds     = leds_reg;
    assign state    = state_reg;
    assign detonate = detonate_reg;

endmodule

// File: tb/tb_destruct_sequencer.sv
// Scoreboard bench for destruct_sequencer: directed scenarios plus random flags against a tick-count model.
module tb_destruct_sequencer;

    localparam int ARM   = 3;
    localparam int STEP  = 4;
    localparam int BLINK = 2;
    localparam int COOL  = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       in_combat = 1'b0;
    logic       danger = 1'b0;
    logic       damaged = 1'b0;
    logic       immobilized = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] leds;
    logic [2:0] state;
    logic       detonate;

    always #5 clk = ~clk;

    destruct_sequencer #(
        .ARM_TICKS   (ARM),
        .STEP_TICKS  (STEP),
        .BLINK_TICKS (BLINK),
        .COOL_TICKS  (COOL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .in_combat   (in_combat),
        .danger      (danger),
        .damaged     (damaged),
        .immobilized (immobilized),
        .abort       (abort),
        .leds        (leds),
        .state       (state),
        .detonate    (detonate)
    );

    typedef struct packed {
        logic [2:0] st;
        logic [7:0] leds;
        logic       det;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;
    int   tests = 0;
    int   fails = 0;
    bit   armed = 0;

    // Reference model: states as integers, countdown tracked as ticks since entry.
    int m_state = 0;
    int m_arm   = 0;
    int m_n     = 0;
    int m_cool  = 0;

    function automatic exp_t model_view();
        exp_t       e;
        logic [7:0] full;
        full   = 8'hFF;
        e.st   = 3'(m_state);
        e.det  = (m_state == 4);
        case (m_state)
            2:       e.leds = (((m_n / BLINK) % 2) == 0) ? 8'(full >> (m_n / STEP)) : 8'h00;
            3:       e.leds = 8'hAA;
            4:       e.leds = 8'hFF;
            default: e.leds = 8'h00;
        endcase
        return e;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_arm   = 0;
        m_n     = 0;
        m_cool  = 0;
    endtask

    task automatic model_tick(input logic c, input logic d, input logic g, input logic i, input logic a);
        bit qual;
        qual = c && ((int'(d) + int'(g) + int'(i)) >= 2);
        case (m_state)
            0: if (qual) begin m_state = 1; m_arm = 1; end
            1: begin
                if (!qual) begin
                    m_state = 0;
                    m_arm   = 0;
                end else begin
                    m_arm++;
                    if (m_arm == ARM) begin m_state = 2; m_n = 0; end
                end
            end
            2: begin
                if (a || !c) begin
                    m_state = 3;
                    m_cool  = 0;
                end else begin
                    m_n++;
                    if (m_n == 8 * STEP) m_state = 4;
                end
            end
            3: begin
                m_cool++;
                if (m_cool == COOL) m_state = 0;
            end
            default: ;
        endcase
    endtask

    task automatic do_tick(input logic c, input logic d, input logic g, input logic i, input logic a);
        @(negedge clk);
        in_combat = c; danger = d; damaged = g; immobilized = i; abort = a;
        tick = 1'b1;
        model_tick(c, d, g, i, a);
        exp_q.push_back(model_view());
        @(negedge clk);
        tick = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic run(input int n, input logic c, input logic d, input logic g, input logic i, input logic a);
        for (int k = 0; k < n; k++) do_tick(c, d, g, i, a);
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rst = 1'b1;
            model_reset();
            exp_q.push_back(model_view());
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check(input string name, input exp_t e);
        tests++;
        if (state !== e.st || leds !== e.leds || detonate !== e.det) begin
            fails++;
            $display("FAIL %s t=%0t: got state=%0d leds=%02h det=%0b, want state=%0d leds=%02h det=%0b",
                     name, $time, state, leds, detonate, e.st, e.leds, e.det);
        end
    endtask

    // Monitor: every tick/reset edge retires one expectation; other edges must hold.
    always @(posedge clk) begin
        if (rst || tick) begin
            #1;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL scoreboard_underflow t=%0t: got no expectation, want one queued", $time);
            end else begin
                last_exp = exp_q.pop_front();
                check("event", last_exp);
                armed = 1;
            end
        end else if (armed) begin
            #1;
            check("hold", last_exp);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset and idle with all flags low
        do_reset(2);
        run(20, 0, 0, 0, 0, 0);

        // Arming filter drops out when critical is lost
        run(2, 1, 1, 1, 0, 0);
        run(2, 1, 1, 0, 0, 0);

        // Full countdown to detonation, then absorbing
        run(ARM + 8 * STEP, 1, 1, 1, 0, 0);
        run(50, 1, 0, 0, 0, 0);

        // Abort on the second tick of the 0x1F step; critical held through cooldown
        do_reset(2);
        run(ARM + 3 * STEP, 1, 0, 1, 1, 0);
        do_tick(1, 0, 1, 1, 1);
        run(COOL, 1, 1, 1, 1, 0);
        run(2, 0, 0, 0, 0, 0);

        // Leaving combat on the final-shift tick wins over detonation
        run(ARM + 8 * STEP - 1, 1, 1, 0, 1, 0);
        do_tick(0, 1, 0, 1, 0);
        run(COOL + 1, 0, 1, 1, 1, 0);

        // Reset mid-countdown and in DETONATE, then re-arm from a full bar
        run(ARM + 2 * STEP + 1, 1, 1, 1, 1, 0);
        do_reset(1);
        run(ARM + 8 * STEP + 3, 1, 1, 1, 0, 0);
        do_reset(1);
        run(ARM + 2, 1, 1, 1, 0, 0);
        do_reset(1);

        // Randomized flags with occasional resets
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 63) == 0) begin
                do_reset(1);
            end else begin
                do_tick($urandom_range(0, 39) != 0,
                        $urandom_range(0, 3) != 0,
                        $urandom_range(0, 3) != 0,
                        $urandom_range(0, 3) != 0,
                        $urandom_range(0, 39) == 0);
            end
        end

        repeat (8) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/destruct_sequencer.md
# destruct_sequencer

Control FSM for the robot self-destruct feature. It consumes the debounced status flags and the 10 ms tick, and applies a 2-of-3 damage rule with an arming filter. It then sequences the 8-step LED countdown, abort/cooldown and terminal detonation, and owns the LED bar and detonate line. It sits between the debouncers and the board LEDs, replacing the free-running countdown/blink glue.

## Interface
Parameters:
- ARM_TICKS, 3: consecutive critical ticks required to start the countdown; must be ≥ 2.
- STEP_TICKS, 100: ticks per countdown step (1 s at a 10 ms tick).
- BLINK_TICKS, 33: ticks per blink half-period during countdown.
- COOL_TICKS, 50: ticks spent in COOLDOWN after an abort.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  single-cycle enable pulse at the 10 ms rate.
- in_combat  in  1  debounced combat-mode flag.
- danger  in  1  debounced flag.
- damaged  in  1  debounced flag.
- immobilized  in  1  debounced flag.
- abort  in  1  debounced manual abort.
- leds  out  8  LED bar.
- state  out  3  current state code.
- detonate  out  1  terminal output; sticky until rst.

## Operation
- critical = at least two of {danger, damaged, immobilized}. It is combinational and sampled only on tick cycles.
- All transitions and counter updates occur only on cycles with tick=1. On other cycles, state and outputs hold.
- States: IDLE=0, ARMING=1, COUNTDOWN=2, COOLDOWN=3, DETONATE=4. Codes 5–7 are illegal and go to IDLE on the next clk.
- IDLE (leds=0x00):
  - on tick with in_combat & critical → ARMING, arm_cnt=1.
- ARMING (leds=0x00):
  - on tick with in_combat & critical: arm_cnt++.
  - when the increment would reach ARM_TICKS → COUNTDOWN.
  - any tick with !in_combat or !critical → IDLE, arm_cnt=0.
- COUNTDOWN:
  - On entry: bar=0xFF, step_cnt=0, blink_cnt=0, blink phase on.
  - Each tick: step_cnt++. When step_cnt reaches STEP_TICKS-1, bar>>=1 and step_cnt=0.
  - Each tick: blink_cnt++. When blink_cnt reaches BLINK_TICKS-1, phase toggles and blink_cnt=0.
  - leds = phase ? bar : 0x00.
  - When a shift produces bar==0x00 → DETONATE. This is 8 steps, i.e. 8·STEP_TICKS ticks after entry.
  - Tick with abort=1 or in_combat=0 → COOLDOWN.
  - Loss of critical alone does not stop the countdown.
- COOLDOWN (leds=0xAA): count COOL_TICKS ticks, then → IDLE. All inputs are ignored here.
- DETONATE (leds=0xFF, detonate=1): absorbing; only rst exits.
- Priority when events coincide on one tick: rst > abort/!in_combat > detonation step > blink/step.
  - Abort on the same tick as the final shift → COOLDOWN, no detonate.
- Widths: each counter is sized by $clog2 of its parameter. bar is 8 bits, logical shift, zero fill.

## Timing
- rst (synchronous, any state including mid-countdown or DETONATE) takes effect at the next clk edge:
  - state=IDLE, leds=0x00, detonate=0.
  - arm_cnt, step_cnt, blink_cnt and cool counter = 0; bar=0xFF; phase=on.
- All outputs are registered. Changes are visible the clk after the qualifying tick cycle; there is no combinational input-to-output path.
- A tick held high N cycles counts as N ticks; upstream must supply single-cycle pulses.
- Timing from first critical tick:
  - COUNTDOWN entry at tick ARM_TICKS.
  - leds=0xFF visible one clk later.
  - detonate asserts one clk after tick ARM_TICKS + 8·STEP_TICKS.

## Structure
- Shared package `destruct_pkg` holds:
  - the state codes;
  - LED constants LED_OFF=0x00, LED_FULL=0xFF, LED_COOL=0xAA.
- One sub-module, `tick_counter`:
  - parameter MAX; inputs clk, rst, clr, en; output done.
  - done pulses when count==MAX-1 with en, then wraps to 0.
  - Instantiated four times: arm, step, blink, cool.
- FSM, bar shifter and LED mux live in destruct_sequencer.

## Test plan
Bench parameters: ARM_TICKS=3, STEP_TICKS=4, BLINK_TICKS=2, COOL_TICKS=5; tick every 4 clk.
1. Reset/idle: rst for 2 clk, all flags 0, 20 ticks → state=0, leds=0x00, detonate=0 throughout.
2. Arming filter: in_combat=1, danger=damaged=1 for 2 ticks, then damaged=0 → ARMING then IDLE, never COUNTDOWN.
3. Full countdown: in_combat=1 and critical held → COUNTDOWN after tick 3.
   - bar sequence 0xFF,0x7F,…,0x01 at 4-tick steps; leds alternate bar/0x00 every 2 ticks.
   - detonate=1, leds=0xFF after tick 35; stays through 50 more ticks.
4. Abort: abort=1 at the 2nd tick of the step where bar=0x1F → COOLDOWN, leds=0xAA for 5 ticks, then IDLE. Flags held critical during cooldown cause no change.
5. Simultaneous: in_combat=0 on the same tick as the final shift to 0x00 → COOLDOWN, detonate stays 0.
6. Reset mid-operation: rst in COUNTDOWN (bar=0x3F) and again in DETONATE → next clk state=0, leds=0x00, detonate=0; re-arm restarts from bar=0xFF.
